udp_rx_parser: RTL and testbench

// - Parses IPv4/UDP headers from the byte stream after eth_parser (Ethernet header already removed).
// - Filters by destination IP and a parametrised UDP port table, then emits payload bytes tagged with the matched port index.
// - Pulses and saturating counters report accepted and dropped datagrams. Sits in the PL_CLK_50M domain, fed by eth_parser.

---
 rtl/udp_rx_parser.sv | 264 ++++++++++++++++++++++++++
 tb/tb_udp_rx_parser.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_parser.sv
// udp_rx_parser: IPv4/UDP header parser and filter behind eth_parser.
// Accepts datagrams addressed to LOCAL_IP whose UDP destination port is in
// PORT_LIST, streams their payload tagged with the matched port index, and
// reports accepted/dropped datagrams through pulses and saturating counters.
// Optional feature: define IPV4_CSUM_CHECK_EN to verify the IPv4 header
// checksum (drop reason 8); undefined, the checksum is ignored.
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   in_data/in_valid/in_eof/in_err     byte stream from eth_parser
//   out_data/out_valid/out_last/out_err payload stream, no backpressure
//   out_port_idx                       matched PORT_LIST index
//   pkt_ok/pkt_drop/drop_reason        per-datagram status
//   ok_cnt/drop_cnt                    saturating status counters
// Drop reasons: 1 version/IHL, 2 fragment, 3 protocol, 4 dst IP, 5 port,
//   6 UDP length, 7 truncated or upstream error, 8 IP checksum.
module udp_rx_parser #(
  parameter logic [31:0]           LOCAL_IP  = 32'hC0A8010A,
  parameter int unsigned           NUM_PORTS = 4,
  parameter logic [NUM_PORTS*16-1:0] PORT_LIST = {16'd5003, 16'd5002, 16'd5001, 16'd5000},
  parameter int unsigned           CNT_W     = 16,
  localparam int unsigned          PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_eof,
  input  logic             in_err,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             out_err,
  output logic [PW-1:0]    out_port_idx,
  output logic             pkt_ok,
  output logic             pkt_drop,
  output logic [3:0]       drop_reason,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  typedef enum logic [2:0] {IP_HDR, UDP_HDR, PAYLOAD, PAD, DROP} state_t;

  state_t      state;
  logic [5:0]  cnt;        // byte index within the current header
  logic [3:0]  ihl;
  logic [7:0]  prev;       // previous accepted byte, high half of 16-bit fields
  logic [31:0] dip;
  logic [15:0] rem;        // payload bytes still expected
  logic [7:0]  hold;       // final payload byte, waits for in_eof
  logic        hold_vld;

  logic [15:0]   word;
  logic          ip_last;
  logic [31:0]   dip_full;
  logic          port_hit;
  logic [PW-1:0] port_sel;
  logic          csum_bad;
  logic          fail;
  logic [3:0]    fail_reason;
  logic          fire_ok;
  logic          fire_drop;
  logic [3:0]    fire_reason;

  assign word     = {prev, in_data};
  assign ip_last  = (cnt == (6'({ihl, 2'b00}) - 6'd1));
  assign dip_full = (cnt == 6'd19) ? {dip[23:0], in_data} : dip;

`ifdef IPV4_CSUM_CHECK_EN
  logic [15:0] csum;
  logic [16:0] csum_raw;
  logic [15:0] csum_nx;

  // Ones'-complement accumulate with end-around carry; cannot overflow twice.
  assign csum_raw = {1'b0, csum} + {1'b0, word};
  assign csum_nx  = csum_raw[15:0] + {15'd0, csum_raw[16]};
  assign csum_bad = (csum_nx != 16'hFFFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= 16'd0;
    end else if (in_valid && state == IP_HDR) begin
      if (cnt == 6'd0)  csum <= 16'd0;
      else if (cnt[0])  csum <= csum_nx;
    end
  end
`else
  assign csum_bad = 1'b0;
`endif

  // Lowest matching port index wins.
  always_comb begin
    port_hit = 1'b0;
    port_sel = '0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if (PORT_LIST[16*i +: 16] == word) begin
        port_hit = 1'b1;
        port_sel = PW'(i);
      end
    end
  end

  // Header checks on the current byte; earlier bytes already passed.
  always_comb begin
    fail        = 1'b0;
    fail_reason = 4'd0;
    if (state == IP_HDR) begin
      if (cnt == 6'd0) begin
        if (in_data[7:4] != 4'd4 || in_data[3:0] < 4'd5) begin
          fail = 1'b1; fail_reason = 4'd1;
        end
      end else if (cnt == 6'd7) begin
        if (prev[5] || {prev[4:0], in_data} != 13'd0) begin
          fail = 1'b1; fail_reason = 4'd2;
        end
      end else if (cnt == 6'd9) begin
        if (in_data != 8'd17) begin
          fail = 1'b1; fail_reason = 4'd3;
        end
      end else if (ip_last) begin
        if (csum_bad) begin
          fail = 1'b1; fail_reason = 4'd8;
        end else if (dip_full != LOCAL_IP) begin
          fail = 1'b1; fail_reason = 4'd4;
        end
      end
    end else if (state == UDP_HDR) begin
      if (cnt == 6'd3 && !port_hit) begin
        fail = 1'b1; fail_reason = 4'd5;
      end else if (cnt == 6'd5 && word < 16'd8) begin
        fail = 1'b1; fail_reason = 4'd6;
      end
    end
  end

  // Datagram completion events; at most one per frame.
  always_comb begin
    fire_ok     = 1'b0;
    fire_drop   = 1'b0;
    fire_reason = 4'd0;
    if (in_valid) begin
      case (state)
        IP_HDR, UDP_HDR: begin
          if (fail) begin
            fire_drop = 1'b1; fire_reason = fail_reason;
          end else if (in_eof) begin
            if (state == UDP_HDR && cnt == 6'd7 && rem == 16'd0 && !in_err) begin
              fire_ok = 1'b1;
            end else begin
              fire_drop = 1'b1; fire_reason = 4'd7;
            end
          end
        end
        PAYLOAD: begin
          if (in_eof) begin
            if (rem == 16'd1 && !in_err) fire_ok = 1'b1;
            else begin
              fire_drop = 1'b1; fire_reason = 4'd7;
            end
          end
        end
        PAD: begin
          if (in_eof) begin
            if (in_err) begin
              fire_drop = 1'b1; fire_reason = 4'd7;
            end else begin
              fire_ok = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Parser state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IP_HDR;
      cnt          <= 6'd0;
      ihl          <= 4'd0;
      prev         <= 8'd0;
      dip          <= 32'd0;
      rem          <= 16'd0;
      hold         <= 8'd0;
      hold_vld     <= 1'b0;
      out_data     <= 8'd0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_err      <= 1'b0;
      out_port_idx <= '0;
      pkt_ok       <= 1'b0;
      pkt_drop     <= 1'b0;
      drop_reason  <= 4'd0;
      ok_cnt       <= '0;
      drop_cnt     <= '0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      pkt_ok    <= fire_ok;
      pkt_drop  <= fire_drop;
      if (fire_drop) drop_reason <= fire_reason;
      if (fire_ok && ok_cnt != '1)     ok_cnt   <= ok_cnt + CNT_W'(1);
      if (fire_drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);

      if (in_valid) begin
        prev <= in_data;
        cnt  <= cnt + 6'd1;

        case (state)
          IP_HDR: begin
            if (cnt == 6'd0) ihl <= in_data[3:0];
            if (cnt >= 6'd16 && cnt <= 6'd19) dip <= {dip[23:0], in_data};
          end
          UDP_HDR: begin
            if (cnt == 6'd3 && port_hit) out_port_idx <= port_sel;
            if (cnt == 6'd5) rem <= word - 16'd8;
            if (cnt == 6'd7) hold_vld <= 1'b0;
          end
          PAYLOAD: begin
            rem <= rem - 16'd1;
            if (in_eof || rem != 16'd1) begin
              out_valid <= 1'b1;
              out_data  <= in_data;
              out_last  <= in_eof;
              out_err   <= in_eof && (rem != 16'd1 || in_err);
            end else begin
              hold     <= in_data;
              hold_vld <= 1'b1;
            end
          end
          PAD: begin
            if (in_eof && hold_vld) begin
              out_valid <= 1'b1;
              out_data  <= hold;
              out_last  <= 1'b1;
              out_err   <= in_err;
              hold_vld  <= 1'b0;
            end
          end
          default: ;
        endcase

        if (in_eof) begin
          state <= IP_HDR;
          cnt   <= 6'd0;
        end else if (fail) begin
          state <= DROP;
        end else begin
          case (state)
            IP_HDR:  if (ip_last) begin state <= UDP_HDR; cnt <= 6'd0; end
            UDP_HDR: if (cnt == 6'd7) begin
                       cnt   <= 6'd0;
                       state <= (rem == 16'd0) ? PAD : PAYLOAD;
                     end
            PAYLOAD: if (rem == 16'd1) state <= PAD;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_udp_rx_parser.sv
// tb_udp_rx_parser: directed frames with hand-computed expectations for
// udp_rx_parser; a second instance with CNT_W=2 shows counter saturation.
module tb_udp_rx_parser;

  localparam logic [31:0] LIP = 32'hC0A8010A;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, in_eof, in_err;

  logic [7:0] out_data;
  logic       out_valid, out_last, out_err;
  logic [1:0] out_port_idx;
  logic       pkt_ok, pkt_drop;
  logic [3:0] drop_reason;
  logic [15:0] ok_cnt, drop_cnt;

  logic [7:0] out_data2;
  logic       out_valid2, out_last2, out_err2;
  logic [1:0] out_port_idx2;
  logic       pkt_ok2, pkt_drop2;
  logic [3:0] drop_reason2;
  logic [1:0] ok_cnt2, drop_cnt2;

  always #5 clk = ~clk;

  udp_rx_parser dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_eof(in_eof), .in_err(in_err), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_err(out_err),
    .out_port_idx(out_port_idx), .pkt_ok(pkt_ok), .pkt_drop(pkt_drop),
    .drop_reason(drop_reason), .ok_cnt(ok_cnt), .drop_cnt(drop_cnt)
  );

  udp_rx_parser #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_eof(in_eof), .in_err(in_err), .out_data(out_data2),
    .out_valid(out_valid2), .out_last(out_last2), .out_err(out_err2),
    .out_port_idx(out_port_idx2), .pkt_ok(pkt_ok2), .pkt_drop(pkt_drop2),
    .drop_reason(drop_reason2), .ok_cnt(ok_cnt2), .drop_cnt(drop_cnt2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  logic [9:0] beats[$];
  time        beat_t[$];
  int         n_ok, n_drop;
  logic [3:0] rsn;
  logic [1:0] idx_seen;
  time        t_ok, t_drop;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        beats.push_back({out_last, out_err, out_data});
        beat_t.push_back($time);
        idx_seen = out_port_idx;
      end
      if (pkt_ok) begin n_ok++; t_ok = $time; end
      if (pkt_drop) begin n_drop++; t_drop = $time; rsn = drop_reason; end
    end
  end

  task automatic clear_mon();
    @(posedge clk); #1;
    beats.delete(); beat_t.delete();
    n_ok = 0; n_drop = 0; rsn = 4'd0; idx_seen = 2'd0; t_ok = 0; t_drop = 0;
  endtask

  logic [7:0] frm[$];
  logic [7:0] pay[$];
  logic [9:0] exp_b[$];
  time        t_sent[256];

  function automatic void build(input logic [3:0] ver, input logic [3:0] ihl,
                                input logic [7:0] flags, input logic [7:0] proto,
                                input logic [31:0] dip, input logic [15:0] dport,
                                input logic [15:0] ulen, input int npad, input bit bad_csum);
    logic [7:0]  h[$];
    int          hl;
    logic [31:0] s;
    logic [15:0] tot;
    logic [15:0] cs;
    hl  = int'(ihl) * 4;
    tot = 16'(hl) + ulen;
    h = {};
    h.push_back({ver, ihl}); h.push_back(8'h00); h.push_back(tot[15:8]); h.push_back(tot[7:0]);
    h.push_back(8'h12); h.push_back(8'h34); h.push_back(flags); h.push_back(8'h00);
    h.push_back(8'h40); h.push_back(proto); h.push_back(8'h00); h.push_back(8'h00);
    h.push_back(8'hC0); h.push_back(8'hA8); h.push_back(8'h01); h.push_back(8'h01);
    h.push_back(dip[31:24]); h.push_back(dip[23:16]); h.push_back(dip[15:8]); h.push_back(dip[7:0]);
    while (h.size() < hl) h.push_back(8'h00);
    s = 0;
    for (int i = 0; i < hl; i += 2) s += {16'd0, h[i], h[i+1]};
    while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    cs = ~s[15:0];
    if (bad_csum) cs = cs ^ 16'h0100;
    h[10] = cs[15:8]; h[11] = cs[7:0];
    frm = h;
    frm.push_back(8'h11); frm.push_back(8'h11);
    frm.push_back(dport[15:8]); frm.push_back(dport[7:0]);
    frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    foreach (pay[i]) frm.push_back(pay[i]);
    for (int i = 0; i < npad; i++) frm.push_back(8'h55);
  endfunction

  // Drive the first n bytes; eof on byte n-1 when with_eof is set.
  task automatic send(input bit err, input int gap_at, input int n, input bit with_eof);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = frm[i];
      in_eof   = with_eof && (i == n - 1);
      in_err   = err && in_eof;
      t_sent[i] = $time;
      if (i == gap_at) begin
        @(negedge clk);
        in_valid = 1'b0; in_eof = 1'b0; in_err = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; in_eof = 1'b0; in_err = 1'b0;
    if (with_eof) repeat (4) @(negedge clk);
  endtask

  task automatic run(input string tag, input bit err, input int gap,
                     input int e_ok, input int e_drop, input logic [3:0] e_rsn);
    clear_mon();
    send(err, gap, frm.size(), 1'b1);
    check({tag, " beats"}, beats.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < beats.size(); i++)
      check($sformatf("%s beat%0d", tag, i), beats[i], exp_b[i]);
    check({tag, " ok"}, n_ok, e_ok);
    check({tag, " drop"}, n_drop, e_drop);
    if (e_drop > 0) check({tag, " reason"}, rsn, e_rsn);
  endtask

  initial begin
    rst = 1'b1; in_data = 8'd0; in_valid = 1'b0; in_eof = 1'b0; in_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst out_valid", out_valid, 0);
    check("rst pkt_ok", pkt_ok, 0);
    check("rst pkt_drop", pkt_drop, 0);
    check("rst ok_cnt", ok_cnt, 0);
    check("rst drop_cnt", drop_cnt, 0);
    check("rst drop_reason", drop_reason, 0);
    check("rst port_idx", out_port_idx, 0);

    // T1: valid datagram to port 5002, payload DE AD BE EF
    pay = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    build(4'h4, 4'd5, 8'h40, 8'd17, LIP, 16'd5002, 16'd12, 0, 1'b0);
    exp_b = {10'h0DE, 10'h0AD, 10'h0BE, 10'h2EF};
    run("T1", 1'b0, 29, 1, 0, 4'd0);
    check("T1 idx", idx_seen, 2);
    check("T1 first beat lat", 32'(beat_t[0] - t_sent[28]), 10);
    check("T1 ok lat", 32'(t_ok - t_sent[31]), 10);
    check("T1 ok_cnt", ok_cnt, 1);
    check("T1 drop_cnt", drop_cnt, 0);

    // T2: same plus 14 pad bytes, upstream error on eof
    build(4'h4, 4'd5, 8'h40, 8'd17, LIP, 16'd5002, 16'd12, 14, 1'b0);
    exp_b = {10'h0DE, 10'h0AD, 10'h0BE, 10'h3EF};
    run("T2", 1'b1, -1, 0, 1, 4'd7);
    check("T2 last lat", 32'(beat_t[3] - t_sent[45]), 10);
    check("T2 drop_cnt", drop_cnt, 1);
    check("T2 ok_cnt", ok_cnt, 1);

    // T3: port 80 rejected after UDP byte 3 (frame byte 23)
    build(4'h4, 4'd5, 8'h40, 8'd17, LIP, 16'd80, 16'd12, 0, 1'b0);
    exp_b = {};
    run("T3", 1'b0, -1, 0, 1, 4'd5);
    check("T3 drop lat", 32'(t_drop - t_sent[23]), 10);
    check("T3 drop_cnt", drop_cnt, 2);

    // T4: IHL=6 with options, port 5000, payload 01 02
    pay = {8'h01, 8'h02};
    build(4'h4, 4'd6, 8'h40, 8'd17, LIP, 16'd5000, 16'd10, 0, 1'b0);
    exp_b = {10'h001, 10'h202};
    run("T4", 1'b0, 5, 1, 0, 4'd0);
    check("T4 idx", idx_seen, 0);

    // T5: UDP len 20 but eof after 3 payload bytes
    pay = {8'hAA, 8'hBB, 8'hCC};
    build(4'h4, 4'd5, 8'h40, 8'd17, LIP, 16'd5001, 16'd20, 0, 1'b0);
    exp_b = {10'h0AA, 10'h0BB, 10'h3CC};
    run("T5", 1'b0, -1, 0, 1, 4'd7);
    check("T5 idx", idx_seen, 1);

    // T6: corrupted IP header checksum
    pay = {8'h77};
    build(4'h4, 4'd5, 8'h40, 8'd17, LIP, 16'd5003, 16'd9, 0, 1'b1);
`ifdef IPV4_CSUM_CHECK_EN
    exp_b = {};
    run("T6", 1'b0, -1, 0, 1, 4'd8);
    check("T6 drop lat", 32'(t_drop - t_sent[19]), 10);
`else
    exp_b = {10'h277};
    run("T6", 1'b0, -1, 1, 0, 4'd0);
    check("T6 idx", idx_seen, 3);
`endif

    // T7..T11: header failures, pulse one cycle after the failing byte
    pay = {8'h10, 8'h20};
    exp_b = {};
    build(4'h6, 4'd5, 8'h40, 8'd17, LIP, 16'd5000, 16'd10, 0, 1'b0);
    run("T7", 1'b0, -1, 0, 1, 4'd1);
    check("T7 drop lat", 32'(t_drop - t_sent[0]), 10);
    build(4'h4, 4'd5, 8'h20, 8'd17, LIP, 16'd5000, 16'd10, 0, 1'b0);
    run("T8", 1'b0, -1, 0, 1, 4'd2);
    check("T8 drop lat", 32'(t_drop - t_sent[7]), 10);
    build(4'h4, 4'd5, 8'h40, 8'd6, LIP, 16'd5000, 16'd10, 0, 1'b0);
    run("T9", 1'b0, -1, 0, 1, 4'd3);
    check("T9 drop lat", 32'(t_drop - t_sent[9]), 10);
    build(4'h4, 4'd5, 8'h40, 8'd17, 32'hC0A8010B, 16'd5000, 16'd10, 0, 1'b0);
    run("T10", 1'b0, -1, 0, 1, 4'd4);
    check("T10 drop lat", 32'(t_drop - t_sent[19]), 10);
    pay = {};
    build(4'h4, 4'd5, 8'h40, 8'd17, LIP, 16'd5000, 16'd6, 0, 1'b0);
    run("T11", 1'b0, -1, 0, 1, 4'd6);
    check("T11 drop lat", 32'(t_drop - t_sent[25]), 10);

    // T12: zero-length payload with 4 pad bytes
    build(4'h4, 4'd5, 8'h40, 8'd17, LIP, 16'd5001, 16'd8, 4, 1'b0);
    run("T12", 1'b0, -1, 1, 0, 4'd0);
    check("T12 ok lat", 32'(t_ok - t_sent[31]), 10);

`ifdef IPV4_CSUM_CHECK_EN
    check("sum ok_cnt", ok_cnt, 3);
    check("sum drop_cnt", drop_cnt, 9);
`else
    check("sum ok_cnt", ok_cnt, 4);
    check("sum drop_cnt", drop_cnt, 8);
`endif
    check("sat drop_cnt2", drop_cnt2, 3);
    check("sat ok_cnt2", ok_cnt2, 3);

    // Reset while the final payload byte is held
    pay = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    build(4'h4, 4'd5, 8'h40, 8'd17, LIP, 16'd5002, 16'd12, 6, 1'b0);
    send(1'b0, -1, 34, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_mon();
    @(negedge clk);
    check("mid-rst out_valid", out_valid, 0);
    check("mid-rst out_last", out_last, 0);
    check("mid-rst ok_cnt", ok_cnt, 0);
    check("mid-rst drop_cnt", drop_cnt, 0);
    check("mid-rst drop_reason", drop_reason, 0);
    repeat (5) @(negedge clk);
    check("mid-rst no beats", beats.size(), 0);

    // Five good datagrams after reset
    build(4'h4, 4'd5, 8'h40, 8'd17, LIP, 16'd5002, 16'd12, 0, 1'b0);
    exp_b = {10'h0DE, 10'h0AD, 10'h0BE, 10'h2EF};
    for (int k = 0; k < 5; k++) run($sformatf("R%0d", k), 1'b0, -1, 1, 0, 4'd0);
    check("post-rst ok_cnt", ok_cnt, 5);
    check("post-rst ok_cnt2 sat", ok_cnt2, 3);
    check("post-rst drop_cnt", drop_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
